// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, load-use/branch control,
// and a pending-write scoreboard for a single variable-latency multi-cycle unit.
module hazard_scoreboard_unit #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Branch_ID,
    input  logic             rs1use_ID,
    input  logic             rs2use_ID,
    input  logic [AW-1:0]    rs1_ID,
    input  logic [AW-1:0]    rs2_ID,
    input  logic [AW-1:0]    rd_ID,
    input  logic             RegWrite_ID,
    input  logic             mc_ID,
    input  logic [AW-1:0]    rd_EXE,
    input  logic [AW-1:0]    rs2_EXE,
    input  logic [AW-1:0]    rd_MEM,
    input  logic             RegWrite_EXE,
    input  logic             DatatoReg_EXE,
    input  logic             mem_w_EXE,
    input  logic             RegWrite_MEM,
    input  logic             DatatoReg_MEM,
    input  logic             issue_mc_EXE,
    input  logic [LAT_W-1:0] mc_lat_EXE,
    output logic             PC_EN_IF,
    output logic             reg_FD_stall,
    output logic             reg_FD_flush,
    output logic             reg_DE_flush,
    output logic [1:0]       forward_ctrl_A,
    output logic [1:0]       forward_ctrl_B,
    output logic             forward_ctrl_ls,
    output logic             mc_busy,
    output logic             mc_wb_valid,
    output logic [AW-1:0]    mc_wb_rd,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_next;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_eff;
    logic [AW-1:0]    mc_rd;

    logic src1_v, src2_v;
    logic unit_long_busy, issue_ok;
    logic load_use, raw_inflight, raw_issuing, waw, structural, stall;

    assign src1_v         = rs1use_ID && (rs1_ID != '0);
    assign src2_v         = rs2use_ID && (rs2_ID != '0);
    assign unit_long_busy = (cnt > LAT_W'(1));
    assign issue_ok       = issue_mc_EXE && !unit_long_busy;
    assign lat_eff        = (mc_lat_EXE == '0) ? LAT_W'(1) : mc_lat_EXE;

    assign mc_busy     = (cnt != '0);
    assign mc_wb_valid = (cnt == LAT_W'(1));
    assign mc_wb_rd    = mc_rd;

    always_comb begin
        load_use     = RegWrite_EXE && DatatoReg_EXE &&
                       ((src1_v && (rs1_ID == rd_EXE)) || (src2_v && (rs2_ID == rd_EXE)));
        raw_inflight = (src1_v && pending[rs1_ID]) || (src2_v && pending[rs2_ID]);
        raw_issuing  = issue_mc_EXE &&
                       ((src1_v && (rs1_ID == rd_EXE)) || (src2_v && (rs2_ID == rd_EXE)));
        waw          = RegWrite_ID && (rd_ID != '0) && pending[rd_ID];
        structural   = mc_ID && (unit_long_busy || issue_mc_EXE);
        stall        = load_use || raw_inflight || raw_issuing || waw || structural;
    end

    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_stall = 1'b0;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        if (stall) begin
            PC_EN_IF     = 1'b0;
            reg_FD_stall = 1'b1;
            reg_DE_flush = 1'b1;
        end else if (Branch_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    // An op sitting in EXE as a multi-cycle issue has no ALU result to forward yet.
    always_comb begin
        forward_ctrl_A = 2'b00;
        if (src1_v) begin
            if (RegWrite_EXE && !issue_mc_EXE && (rd_EXE == rs1_ID))
                forward_ctrl_A = 2'b01;
            else if (RegWrite_MEM && (rd_MEM == rs1_ID))
                forward_ctrl_A = DatatoReg_MEM ? 2'b11 : 2'b10;
        end
        forward_ctrl_B = 2'b00;
        if (src2_v) begin
            if (RegWrite_EXE && !issue_mc_EXE && (rd_EXE == rs2_ID))
                forward_ctrl_B = 2'b01;
            else if (RegWrite_MEM && (rd_MEM == rs2_ID))
                forward_ctrl_B = DatatoReg_MEM ? 2'b11 : 2'b10;
        end
    end

    assign forward_ctrl_ls = mem_w_EXE && RegWrite_MEM && DatatoReg_MEM &&
                             (rd_MEM == rs2_EXE) && (rs2_EXE != '0);

    // Clear is applied before set so a back-to-back reissue to the same rd keeps it pending.
    always_comb begin
        pending_next = pending;
        if (cnt == LAT_W'(1))
            pending_next[mc_rd] = 1'b0;
        if (issue_ok && (rd_EXE != '0))
            pending_next[rd_EXE] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            cnt       <= '0;
            mc_rd     <= '0;
            mc_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pending <= pending_next;
            if (issue_ok) begin
                cnt   <= lat_eff;
                mc_rd <= rd_EXE;
            end else if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (issue_mc_EXE && unit_long_busy)
                mc_err <= 1'b1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: vector table under reset, directed multi-cycle
// sequences, and random stimulus against a timeline-based reference model.
module tb_hazard_scoreboard_unit;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int LAT_W = 4;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Branch_ID, rs1use_ID, rs2use_ID, RegWrite_ID, mc_ID;
    logic [AW-1:0]    rs1_ID, rs2_ID, rd_ID, rd_EXE, rs2_EXE, rd_MEM;
    logic             RegWrite_EXE, DatatoReg_EXE, mem_w_EXE, RegWrite_MEM, DatatoReg_MEM;
    logic             issue_mc_EXE;
    logic [LAT_W-1:0] mc_lat_EXE;
    logic             PC_EN_IF, reg_FD_stall, reg_FD_flush, reg_DE_flush;
    logic [1:0]       forward_ctrl_A, forward_ctrl_B;
    logic             forward_ctrl_ls, mc_busy, mc_wb_valid, mc_err;
    logic [AW-1:0]    mc_wb_rd;
    logic [CW-1:0]    stall_cnt;

    hazard_scoreboard_unit #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Branch_ID(Branch_ID),
        .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .RegWrite_ID(RegWrite_ID), .mc_ID(mc_ID),
        .rd_EXE(rd_EXE), .rs2_EXE(rs2_EXE), .rd_MEM(rd_MEM),
        .RegWrite_EXE(RegWrite_EXE), .DatatoReg_EXE(DatatoReg_EXE), .mem_w_EXE(mem_w_EXE),
        .RegWrite_MEM(RegWrite_MEM), .DatatoReg_MEM(DatatoReg_MEM),
        .issue_mc_EXE(issue_mc_EXE), .mc_lat_EXE(mc_lat_EXE),
        .PC_EN_IF(PC_EN_IF), .reg_FD_stall(reg_FD_stall), .reg_FD_flush(reg_FD_flush),
        .reg_DE_flush(reg_DE_flush), .forward_ctrl_A(forward_ctrl_A),
        .forward_ctrl_B(forward_ctrl_B), .forward_ctrl_ls(forward_ctrl_ls),
        .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_rd(mc_wb_rd),
        .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one op in flight, described by its destination and the
    // cycle index in which its result writes back.
    int cyc = 0;
    bit m_active = 0;
    int m_rd = 0;
    int m_wb_cyc = 0;
    bit m_err = 0;
    int m_scnt = 0;

    bit e_stall, e_pc, e_fds, e_ffl, e_dfl, e_fls, e_busy, e_wbv;
    int e_fa, e_fb;

    typedef struct {
        int br, r1u, r2u, rs1, rs2, rdid, rwid, mcid;
        int rdx, rs2x, rdm, rwx, drx, mwx, rwm, drm, iss;
        int pc, fds, ffl, dfl, fa, fb, fls;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(input int r);
        return m_active && (r != 0) && (r == m_rd);
    endfunction

    function automatic int fwd(input bit used, input int rs);
        if (!used || rs == 0) return 0;
        if (RegWrite_EXE && !issue_mc_EXE && int'(rd_EXE) == rs) return 1;
        if (RegWrite_MEM && int'(rd_MEM) == rs) return DatatoReg_MEM ? 3 : 2;
        return 0;
    endfunction

    task automatic model_eval();
        bit u1, u2, long_busy;
        u1 = rs1use_ID && (rs1_ID != 0);
        u2 = rs2use_ID && (rs2_ID != 0);
        long_busy = m_active && (cyc < m_wb_cyc);
        e_stall = (RegWrite_EXE && DatatoReg_EXE && ((u1 && rs1_ID == rd_EXE) || (u2 && rs2_ID == rd_EXE)))
               || (u1 && m_pend(int'(rs1_ID))) || (u2 && m_pend(int'(rs2_ID)))
               || (issue_mc_EXE && ((u1 && rs1_ID == rd_EXE) || (u2 && rs2_ID == rd_EXE)))
               || (RegWrite_ID && m_pend(int'(rd_ID)))
               || (mc_ID && (long_busy || issue_mc_EXE));
        e_pc  = !e_stall;
        e_fds = e_stall;
        e_dfl = e_stall;
        e_ffl = !e_stall && Branch_ID;
        e_fa  = fwd(rs1use_ID, int'(rs1_ID));
        e_fb  = fwd(rs2use_ID, int'(rs2_ID));
        e_fls = mem_w_EXE && RegWrite_MEM && DatatoReg_MEM && (rd_MEM == rs2_EXE) && (rs2_EXE != 0);
        e_busy = m_active;
        e_wbv  = m_active && (cyc == m_wb_cyc);
    endtask

    task automatic model_edge();
        bit can;
        if (!rst_n) begin
            m_active = 0; m_rd = 0; m_err = 0; m_scnt = 0;
        end else begin
            can = !(m_active && cyc < m_wb_cyc);
            if (m_active && cyc == m_wb_cyc) m_active = 0;
            if (issue_mc_EXE) begin
                if (can) begin
                    m_active = 1;
                    m_rd = int'(rd_EXE);
                    m_wb_cyc = cyc + ((mc_lat_EXE == 0) ? 1 : int'(mc_lat_EXE));
                end else begin
                    m_err = 1;
                end
            end
            if (e_stall && m_scnt < (1 << CW) - 1) m_scnt++;
        end
        cyc++;
    endtask

    task automatic check_model();
        model_eval();
        chk("pc_en", PC_EN_IF, e_pc);
        chk("fd_stall", reg_FD_stall, e_fds);
        chk("fd_flush", reg_FD_flush, e_ffl);
        chk("de_flush", reg_DE_flush, e_dfl);
        chk("fwd_a", forward_ctrl_A, e_fa);
        chk("fwd_b", forward_ctrl_B, e_fb);
        chk("fwd_ls", forward_ctrl_ls, e_fls);
        chk("mc_busy", mc_busy, e_busy);
        chk("mc_wb_valid", mc_wb_valid, e_wbv);
        chk("mc_wb_rd", mc_wb_rd, m_rd);
        chk("mc_err", mc_err, m_err);
        chk("stall_cnt", stall_cnt, m_scnt);
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        Branch_ID = 0; rs1use_ID = 0; rs2use_ID = 0; RegWrite_ID = 0; mc_ID = 0;
        rs1_ID = 0; rs2_ID = 0; rd_ID = 0; rd_EXE = 0; rs2_EXE = 0; rd_MEM = 0;
        RegWrite_EXE = 0; DatatoReg_EXE = 0; mem_w_EXE = 0; RegWrite_MEM = 0;
        DatatoReg_MEM = 0; issue_mc_EXE = 0; mc_lat_EXE = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_mc_EXE = 1;
        rd_EXE = AW'(rd);
        mc_lat_EXE = LAT_W'(lat);
    endtask

    initial begin
        //         br r1u r2u rs1 rs2 rdid rwid mcid rdx rs2x rdm rwx drx mwx rwm drm iss | pc fds ffl dfl fa fb fls
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 5, 0, 0, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0};
        vt[2]  = '{0, 0, 1, 0, 6, 0, 0, 0,  6, 0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0};
        vt[3]  = '{0, 1, 0, 9, 0, 0, 0, 0,  0, 0, 9, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 2, 0, 0};
        vt[4]  = '{0, 1, 1, 9, 9, 0, 0, 0,  0, 0, 9, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 3, 3, 0};
        vt[5]  = '{0, 1, 0, 4, 0, 0, 0, 0,  4, 0, 4, 1, 0, 0, 1, 1, 0,   1, 0, 0, 0, 1, 0, 0};
        vt[6]  = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 1, 1, 0,   1, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 5, 0, 0, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0};
        vt[8]  = '{0, 0, 1, 0, 7, 0, 0, 0,  7, 0, 0, 1, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 0, 0};
        vt[10] = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 0};
        vt[11] = '{1, 1, 0, 5, 0, 0, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 1, 1, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 8, 8, 0, 0, 1, 1, 1, 0,   1, 0, 0, 0, 0, 0, 1};
        vt[13] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1, 1, 0,   1, 0, 0, 0, 0, 0, 0};
        vt[14] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 8, 8, 0, 0, 1, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0};
        vt[15] = '{0, 0, 1, 0, 3, 3, 1, 1,  3, 0, 3, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 2, 0};

        clear_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;

        // Combinational vectors applied with the scoreboard held idle in reset.
        for (int i = 0; i < 16; i++) begin
            Branch_ID = 1'(vt[i].br); rs1use_ID = 1'(vt[i].r1u); rs2use_ID = 1'(vt[i].r2u);
            rs1_ID = AW'(vt[i].rs1); rs2_ID = AW'(vt[i].rs2); rd_ID = AW'(vt[i].rdid);
            RegWrite_ID = 1'(vt[i].rwid); mc_ID = 1'(vt[i].mcid);
            rd_EXE = AW'(vt[i].rdx); rs2_EXE = AW'(vt[i].rs2x); rd_MEM = AW'(vt[i].rdm);
            RegWrite_EXE = 1'(vt[i].rwx); DatatoReg_EXE = 1'(vt[i].drx); mem_w_EXE = 1'(vt[i].mwx);
            RegWrite_MEM = 1'(vt[i].rwm); DatatoReg_MEM = 1'(vt[i].drm);
            issue_mc_EXE = 1'(vt[i].iss); mc_lat_EXE = 4'd3;
            #1;
            chk($sformatf("vec%0d_pc", i), PC_EN_IF, vt[i].pc);
            chk($sformatf("vec%0d_fds", i), reg_FD_stall, vt[i].fds);
            chk($sformatf("vec%0d_ffl", i), reg_FD_flush, vt[i].ffl);
            chk($sformatf("vec%0d_dfl", i), reg_DE_flush, vt[i].dfl);
            chk($sformatf("vec%0d_fa", i), forward_ctrl_A, vt[i].fa);
            chk($sformatf("vec%0d_fb", i), forward_ctrl_B, vt[i].fb);
            chk($sformatf("vec%0d_fls", i), forward_ctrl_ls, vt[i].fls);
            chk($sformatf("vec%0d_busy", i), mc_busy, 0);
            tick();
        end

        // Load-use: one stall cycle, then the load is forwarded from MEM.
        do_reset();
        rs1use_ID = 1; rs1_ID = 5; rd_EXE = 5; RegWrite_EXE = 1; DatatoReg_EXE = 1;
        #1; chk("lu_stall_pc", PC_EN_IF, 0); chk("lu_stall_fds", reg_FD_stall, 1);
        chk("lu_stall_dfl", reg_DE_flush, 1);
        tick();
        rd_EXE = 0; RegWrite_EXE = 0; DatatoReg_EXE = 0; rd_MEM = 5; RegWrite_MEM = 1; DatatoReg_MEM = 1;
        #1; chk("lu_fwd_a", forward_ctrl_A, 3); chk("lu_nostall", PC_EN_IF, 1);
        tick();

        // Multi-cycle latency 4 with a dependent reader in ID.
        do_reset();
        rs2use_ID = 1; rs2_ID = 7; issue(7, 4);
        #1; chk("mc4_issue_stall", reg_FD_stall, 1);
        tick();
        issue_mc_EXE = 0; rd_EXE = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("mc4_wbv_c%0d", k), mc_wb_valid, (k == 4));
            chk($sformatf("mc4_stall_c%0d", k), reg_FD_stall, 1);
            chk($sformatf("mc4_busy_c%0d", k), mc_busy, 1);
            if (k == 4) begin
                chk("mc4_wb_rd", mc_wb_rd, 7);
                chk("mc4_stall_cnt", stall_cnt, 4);
            end
            tick();
        end
        #1; chk("mc4_released", reg_FD_stall, 0); chk("mc4_idle", mc_busy, 0);
        tick();

        // Structural stall and issue-while-busy error.
        do_reset();
        issue(9, 5);
        tick();
        clear_inputs();
        tick(); tick();
        mc_ID = 1; issue(10, 2);
        #1; chk("struct_stall", PC_EN_IF, 0);
        tick();
        clear_inputs();
        #1; chk("err_set", mc_err, 1); chk("err_rd_kept", mc_wb_rd, 9);
        for (int k = 0; k < 4; k++) tick();
        #1; chk("err_sticky", mc_err, 1);
        do_reset();
        #1; chk("err_cleared", mc_err, 0);

        // Branch with and without a pending-RAW stall.
        issue(12, 3);
        tick();
        clear_inputs();
        Branch_ID = 1; rs1use_ID = 1; rs1_ID = 12;
        #1; chk("br_stall_ffl", reg_FD_flush, 0); chk("br_stall_pc", PC_EN_IF, 0);
        tick();
        rs1use_ID = 0;
        #1; chk("br_ffl", reg_FD_flush, 1); chk("br_pc", PC_EN_IF, 1);
        tick(); tick();

        // Reset in the middle of a long operation drops it.
        do_reset();
        issue(4, 6);
        tick();
        clear_inputs();
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        RegWrite_ID = 1; rd_ID = 4;
        #1; chk("rst_busy", mc_busy, 0); chk("rst_waw_gone", reg_FD_stall, 0);
        for (int k = 0; k < 8; k++) begin
            #1; chk($sformatf("rst_no_wb%0d", k), mc_wb_valid, 0);
            tick();
        end

        // Back-to-back issue to the same register on the completion cycle.
        do_reset();
        issue(3, 1);
        tick();
        RegWrite_ID = 1; rd_ID = 3;
        #1; chk("b2b_wb1", mc_wb_valid, 1); chk("b2b_rd1", mc_wb_rd, 3); chk("b2b_waw1", reg_FD_stall, 1);
        tick();
        issue_mc_EXE = 0; rd_EXE = 0;
        #1; chk("b2b_wb2", mc_wb_valid, 1); chk("b2b_pend_kept", reg_FD_stall, 1);
        chk("b2b_err", mc_err, 0);
        tick();
        #1; chk("b2b_done", mc_wb_valid, 0); chk("b2b_pend_clr", reg_FD_stall, 0);
        tick();

        // Counter saturation under a held load-use stall.
        do_reset();
        rs1use_ID = 1; rs1_ID = 2; rd_EXE = 2; RegWrite_EXE = 1; DatatoReg_EXE = 1;
        for (int k = 0; k < 70; k++) tick();
        #1; chk("cnt_saturated", stall_cnt, (1 << CW) - 1);
        tick();

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 399) != 0);
            Branch_ID    = 1'($urandom_range(0, 3) == 0);
            rs1use_ID    = 1'($urandom);
            rs2use_ID    = 1'($urandom);
            rs1_ID       = AW'($urandom_range(0, 7));
            rs2_ID       = AW'($urandom_range(0, 7));
            rd_ID        = AW'($urandom_range(0, 7));
            RegWrite_ID  = 1'($urandom);
            mc_ID        = 1'($urandom_range(0, 3) == 0);
            rd_EXE       = AW'($urandom_range(0, 7));
            rs2_EXE      = AW'($urandom_range(0, 7));
            rd_MEM       = AW'($urandom_range(0, 7));
            RegWrite_EXE = 1'($urandom);
            DatatoReg_EXE = 1'($urandom_range(0, 3) == 0);
            mem_w_EXE    = 1'($urandom);
            RegWrite_MEM = 1'($urandom);
            DatatoReg_MEM = 1'($urandom);
            issue_mc_EXE = 1'($urandom_range(0, 2) == 0);
            mc_lat_EXE   = LAT_W'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
